// File: rtl/sd_frame_loader.sv
// sd_frame_loader: collects ten channel coefficients and 4-element receive
// vectors from a valid/ready word stream. It plays the channel to the decoder
// as three beats, then streams buffered receive vectors one per OutputReady.
// Optional macro SD_FRAME_LOADER_STATS_EN adds a saturating delivered-vector
// counter on vec_count; without it vec_count is tied to zero.
module sd_frame_loader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_type,
  input  logic [WIDTH-1:0]   s_real,
  input  logic [WIDTH-1:0]   s_imag,
  input  logic               flush,
  output logic               flagChannelorData,
  output logic [8*WIDTH-1:0] InData,
  input  logic               OutputReady,
  output logic               underrun,
  output logic [15:0]        vec_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned VW = 8 * WIDTH;
  localparam logic [AW:0] FullCount = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StChWait, StSend0, StSend1, StSend2, StRun} state_e;

  state_e          state_q, state_d;
  logic [3:0]      ch_idx_q, ch_idx_d;
  logic [1:0]      dat_idx_q, dat_idx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            flag_q, flag_d;
  logic [VW-1:0]   indata_q, indata_d;
  logic            underrun_q, underrun_d;

  logic [WIDTH-1:0] ch_re  [10];
  logic [WIDTH-1:0] ch_im  [10];
  logic [WIDTH-1:0] asm_re [3];
  logic [WIDTH-1:0] asm_im [3];
  logic [VW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [VW-1:0]    beat [3];

  logic ch_acc, dat_acc, fifo_empty, push, pop_req, do_pop;

  // Combinational handshake: data readiness uses the registered count only.
  assign s_ready    = Reset && (s_type ? (count_q != FullCount) : (state_q == StIdle));
  assign ch_acc     = s_valid && s_ready && !s_type;
  assign dat_acc    = s_valid && s_ready && s_type;
  assign fifo_empty = (count_q == '0);
  assign push       = dat_acc && (dat_idx_q == 2'd3) && !flush;
  // The edge entering RUN is the first pop; afterwards the decoder strobe pops.
  assign pop_req    = !flush && ((state_q == StSend2) || ((state_q == StRun) && OutputReady));
  assign do_pop     = pop_req && !fifo_empty;

  // Channel beats: lane pair k of beat b carries coefficient 4b+k (zero past R9).
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      beat[b] = '0;
      for (int k = 0; k < 4; k++) begin
        if (4*b + k < 10) begin
          beat[b][2*k*WIDTH +: WIDTH]     = ch_re[4*b+k];
          beat[b][(2*k+1)*WIDTH +: WIDTH] = ch_im[4*b+k];
        end
      end
    end
  end

  // Next-state, FIFO bookkeeping and registered-output values.
  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    dat_idx_d  = dat_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flag_d     = flag_q;
    indata_d   = indata_q;
    underrun_d = underrun_q;
    if (flush) begin
      state_d   = StIdle;
      ch_idx_d  = '0;
      dat_idx_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      flag_d    = 1'b0;
      indata_d  = '0;
    end else begin
      if (dat_acc) dat_idx_d = dat_idx_q + 2'd1;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (pop_req && fifo_empty) underrun_d = 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);

      unique case (state_q)
        StIdle: begin
          if (ch_acc) begin
            if (ch_idx_q == 4'd9) begin
              state_d  = StChWait;
              ch_idx_d = '0;
            end else begin
              ch_idx_d = ch_idx_q + 4'd1;
            end
          end
        end
        StChWait: if (!fifo_empty) state_d = StSend0;
        StSend0:  state_d = StSend1;
        StSend1:  state_d = StSend2;
        StSend2:  state_d = StRun;
        StRun:    state_d = StRun;
        default:  state_d = StIdle;
      endcase

      unique case (state_d)
        StSend0: begin flag_d = 1'b1; indata_d = beat[0]; end
        StSend1: begin flag_d = 1'b1; indata_d = beat[1]; end
        StSend2: begin flag_d = 1'b1; indata_d = beat[2]; end
        StRun: begin
          flag_d = 1'b0;
          if (pop_req) indata_d = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
        end
        default: begin flag_d = 1'b0; indata_d = '0; end
      endcase
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= StIdle;
      ch_idx_q   <= '0;
      dat_idx_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      flag_q     <= 1'b0;
      indata_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_idx_q   <= ch_idx_d;
      dat_idx_q  <= dat_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flag_q     <= flag_d;
      indata_q   <= indata_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage arrays; validity is tracked by the indices and count above.
  always_ff @(posedge Clk) begin
    if (ch_acc) begin
      ch_re[ch_idx_q] <= s_real;
      ch_im[ch_idx_q] <= s_imag;
    end
    if (dat_acc && (dat_idx_q != 2'd3)) begin
      asm_re[dat_idx_q] <= s_real;
      asm_im[dat_idx_q] <= s_imag;
    end
    if (push) begin
      fifo_mem[wr_ptr_q] <= {s_imag, asm_im[2], asm_im[1], asm_im[0],
                             s_real, asm_re[2], asm_re[1], asm_re[0]};
    end
  end

  assign flagChannelorData = flag_q;
  assign InData            = indata_q;
  assign underrun          = underrun_q;

`ifdef SD_FRAME_LOADER_STATS_EN
  logic [15:0] vec_cnt_q;

  // Saturating count of vectors actually delivered (underrun pops excluded).
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      vec_cnt_q <= '0;
    end else if (do_pop && (vec_cnt_q != 16'hFFFF)) begin
      vec_cnt_q <= vec_cnt_q + 16'd1;
    end
  end

  assign vec_count = vec_cnt_q;
`else
  assign vec_count = 16'd0;
`endif

endmodule

// File: tb/tb_sd_frame_loader.sv
// Scoreboard bench for sd_frame_loader: expected decoder beats are queued as
// stimulus is issued; a monitor compares whenever a channel beat, the end of
// the channel beats, or the beat following an OutputReady strobe is presented.
module tb_sd_frame_loader;
  localparam int W  = 32;
  localparam int VW = 8 * W;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_type = 1'b0;
  logic [W-1:0]  s_real = '0;
  logic [W-1:0]  s_imag = '0;
  logic          flush = 1'b0;
  logic          flagChannelorData;
  logic [VW-1:0] InData;
  logic          OutputReady = 1'b0;
  logic          underrun;
  logic [15:0]   vec_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          flag;
    logic [VW-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  sd_frame_loader #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .s_valid(s_valid), .s_ready(s_ready), .s_type(s_type),
    .s_real(s_real), .s_imag(s_imag), .flush(flush),
    .flagChannelorData(flagChannelorData), .InData(InData), .OutputReady(OutputReady),
    .underrun(underrun), .vec_count(vec_count)
  );

  always #5 Clk = ~Clk;

  // Expected vec_count after n good pops.
  function automatic logic [VW-1:0] vc(input int n);
`ifdef SD_FRAME_LOADER_STATS_EN
    return VW'(n);
`else
    return VW'(0 * n);
`endif
  endfunction

  // Channel beat b for R_k = (k, -k).
  function automatic logic [VW-1:0] chan_beat(input int b);
    logic [VW-1:0] v;
    int w;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      w = 4 * b + k;
      if (w < 10) begin
        v[64*k +: 32]    = 32'(w);
        v[64*k+32 +: 32] = 32'(-w);
      end
    end
    return v;
  endfunction

  // Receive vector y_i = (re_base+i, im_base+i): reals in lanes 0..3, imags in 4..7.
  function automatic logic [VW-1:0] vec_data(input int re_base, input int im_base);
    logic [VW-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v[32*i +: 32]     = 32'(re_base + i);
      v[128+32*i +: 32] = 32'(im_base + i);
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic expect_beat(input logic f, input logic [VW-1:0] d);
    exp_t e;
    e.flag = f;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_channel();
    for (int b = 0; b < 3; b++) expect_beat(1'b1, chan_beat(b));
  endtask

  task automatic run_monitor();
    logic or_seen;
    logic flag_prev;
    exp_t e;
    flag_prev = 1'b0;
    forever begin
      @(posedge Clk);
      or_seen = OutputReady && Reset && !flush;
      @(negedge Clk);
      if (flagChannelorData || flag_prev || or_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected flag=%0b data=%h", flagChannelorData, InData);
        end else begin
          e = exp_q.pop_front();
          if (flagChannelorData !== e.flag || InData !== e.data) begin
            errors++;
            $display("FAIL beat: got flag=%0b data=%h want flag=%0b data=%h",
                     flagChannelorData, InData, e.flag, e.data);
          end
        end
      end
      flag_prev = flagChannelorData;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d beats missing want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_word(input logic t, input int re, input int im);
    int n;
    @(negedge Clk);
    s_valid = 1'b1;
    s_type  = t;
    s_real  = 32'(re);
    s_imag  = 32'(im);
    #1;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_word: got s_ready=0 want 1 within 200 cycles");
    end
    @(posedge Clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic load_channel();
    for (int k = 0; k < 10; k++) send_word(1'b0, k, -k);
  endtask

  task automatic load_vector(input int re_base, input int im_base);
    for (int i = 0; i < 4; i++) send_word(1'b1, re_base + i, im_base + i);
  endtask

  task automatic pulse_or();
    @(negedge Clk);
    OutputReady = 1'b1;
    @(negedge Clk);
    OutputReady = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    fork
      run_monitor();
    join_none

    // Reset values.
    @(negedge Clk);
    #1;
    check("s_ready_in_reset", VW'(s_ready), VW'(0));
    @(negedge Clk);
    check("rst_flag", VW'(flagChannelorData), VW'(0));
    check("rst_indata", InData, '0);
    check("rst_underrun", VW'(underrun), VW'(0));
    check("rst_vec_count", VW'(vec_count), VW'(0));
    Reset = 1'b1;
    #1;
    check("rst_ready_channel", VW'(s_ready), VW'(1));
    s_type = 1'b1;
    #1;
    check("rst_ready_data", VW'(s_ready), VW'(1));

    // Basic frame: channel then one vector.
    load_channel();
    check("ch_wait_refuses_channel", VW'(s_ready), VW'(0));
    check("ch_wait_flag", VW'(flagChannelorData), VW'(0));
    expect_channel();
    expect_beat(1'b0, vec_data(10, 20));
    load_vector(10, 20);
    wait_drain("basic_frame");
    @(negedge Clk);
    s_type = 1'b0;
    #1;
    check("run_refuses_channel", VW'(s_ready), VW'(0));
    check("basic_underrun", VW'(underrun), VW'(0));
    check("basic_vec_count", VW'(vec_count), vc(1));

    // Underrun on empty FIFO.
    expect_beat(1'b0, '0);
    pulse_or();
    wait_drain("underrun_beat");
    check("underrun_set", VW'(underrun), VW'(1));
    check("underrun_vec_count", VW'(vec_count), vc(1));

    // Full FIFO before channel, then streaming.
    do_reset();
    for (int j = 0; j < 4; j++) load_vector(40 + 10 * j, 80 + 10 * j);
    @(negedge Clk);
    s_valid = 1'b1;
    s_type  = 1'b1;
    s_real  = 32'(80);
    s_imag  = 32'(120);
    #1;
    check("full_refuses_data", VW'(s_ready), VW'(0));
    @(negedge Clk);
    #1;
    check("full_refuses_data_2", VW'(s_ready), VW'(0));
    s_valid = 1'b0;
    s_type  = 1'b0;
    #1;
    check("full_idle_accepts_channel", VW'(s_ready), VW'(1));
    expect_channel();
    expect_beat(1'b0, vec_data(40, 80));
    load_channel();
    wait_drain("full_frame");
    expect_beat(1'b0, vec_data(50, 90));
    pulse_or();
    wait_drain("second_vector");
    s_type = 1'b1;
    #1;
    check("data_ready_after_pop", VW'(s_ready), VW'(1));
    for (int i = 0; i < 3; i++) send_word(1'b1, 80 + i, 120 + i);

    // y3 push and decoder pop in the same cycle with two queued.
    expect_beat(1'b0, vec_data(60, 100));
    @(negedge Clk);
    s_valid = 1'b1;
    s_type = 1'b1;
    s_real = 32'(83);
    s_imag = 32'(123);
    OutputReady = 1'b1;
    #1;
    check("simul_push_ready", VW'(s_ready), VW'(1));
    @(negedge Clk);
    s_valid = 1'b0;
    OutputReady = 1'b0;
    wait_drain("simul_pop");
    expect_beat(1'b0, vec_data(70, 110));
    pulse_or();
    expect_beat(1'b0, vec_data(80, 120));
    pulse_or();
    check("no_underrun_yet", VW'(underrun), VW'(0));
    expect_beat(1'b0, '0);
    pulse_or();
    wait_drain("drain_order");
    check("drain_underrun", VW'(underrun), VW'(1));
    check("drain_vec_count", VW'(vec_count), vc(5));

    // Flush during the second channel beat.
    do_reset();
    load_vector(1, 2);
    expect_beat(1'b1, chan_beat(0));
    expect_beat(1'b1, chan_beat(1));
    expect_beat(1'b0, '0);
    load_channel();
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    s_type = 1'b0;
    #1;
    check("flush_flag", VW'(flagChannelorData), VW'(0));
    check("flush_ready_channel", VW'(s_ready), VW'(1));
    wait_drain("flush_beats");

    // Reset in the middle of RUN.
    load_vector(5, 6);
    expect_channel();
    expect_beat(1'b0, vec_data(5, 6));
    load_channel();
    wait_drain("post_flush_frame");
    expect_beat(1'b0, '0);
    pulse_or();
    wait_drain("pre_reset_underrun");
    check("pre_reset_underrun", VW'(underrun), VW'(1));
    @(negedge Clk);
    Reset = 1'b0;
    s_type = 1'b0;
    #1;
    check("mid_reset_ready", VW'(s_ready), VW'(0));
    @(negedge Clk);
    check("mid_reset_flag", VW'(flagChannelorData), VW'(0));
    check("mid_reset_indata", InData, '0);
    check("mid_reset_underrun", VW'(underrun), VW'(0));
    check("mid_reset_vec_count", VW'(vec_count), VW'(0));
    Reset = 1'b1;
    #1;
    check("post_reset_ready", VW'(s_ready), VW'(1));
    repeat (3) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_frame_loader.md
SD_FRAME_LOADER -- requirements
Module: sd_frame_loader

Interface
REQ-001 Parameter WIDTH, default 32: bits per real or imaginary component.
REQ-002 Parameter FIFO_DEPTH, default 4: number of buffered 4-element receive vectors, power of 2, at least 2.
REQ-003 Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 s_valid  input  1  upstream word valid.
REQ-006 s_ready  output  1  loader accepts the word this cycle; transfer when s_valid and s_ready are both 1.
REQ-007 s_type  input  1  0 = channel coefficient R0..R9, 1 = receive sample y0..y3.
REQ-008 s_real, s_imag  input  WIDTH each  signed complex word.
REQ-009 flush  input  1  return to IDLE; empty the FIFO; discard partial assemblies.
REQ-010 flagChannelorData  output  1  1 = channel beat on InData, 0 = data.
REQ-011 InData  output  8*WIDTH  packed beat to the decoder.
REQ-012 OutputReady  input  1  decoder result strobe; decoder latches InData in that cycle.
REQ-013 underrun  output  1  sticky: decoder consumed a vector while the FIFO was empty.
REQ-014 vec_count  output  16  count of vectors delivered (see REQ-032).

Function
REQ-015 States SHALL be IDLE, CH_WAIT, SEND0, SEND1, SEND2, RUN.
REQ-016 Channel words SHALL be accepted only in IDLE, in order R0..R9, tracked by a 4-bit index.
REQ-017 On acceptance of R9 the state SHALL go IDLE->CH_WAIT and the index SHALL return to 0.
REQ-018 Data words SHALL be accepted in any state, in order y0..y3, into an assembly register.
REQ-019 Acceptance of y3 SHALL push the assembled vector into the FIFO in the same edge.
REQ-020 s_ready SHALL equal (s_type=0 and state=IDLE) or (s_type=1 and FIFO not full, from the registered count), with no same-cycle pop bypass; s_ready SHALL be 0 during Reset.
REQ-021 State transitions:
- CH_WAIT->SEND0 when the FIFO is non-empty.
- SEND0->SEND1->SEND2->RUN unconditionally, one cycle each.
REQ-022 In SEND0, SEND1 and SEND2, flagChannelorData=1 and InData SHALL carry beat b (b=0,1,2):
- Lane pair k (k=0..3) holds word 4b+k: real in bits [WIDTH*(2k+1)-1 : WIDTH*2k], imaginary in the next WIDTH bits.
- SEND2 lanes for k=2,3 SHALL be zero.
REQ-023 In RUN, flagChannelorData=0 and InData SHALL present the FIFO head:
- y0..y3 real parts in lanes 0..3.
- y0..y3 imaginary parts in lanes 4..7.
REQ-024 In RUN, the head SHALL be popped on the first RUN cycle, and thereafter on every cycle with OutputReady=1.
REQ-025 The next head (or zero) SHALL appear on InData the following cycle.
REQ-026 A pop with the FIFO empty SHALL set underrun, drive InData to zero the next cycle, and leave FIFO pointers unchanged.
REQ-027 Simultaneous push and pop SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 In RUN the loader SHALL stay in RUN, and channel words SHALL be refused.
REQ-029 flush=1 SHALL take priority over all other events:
- Next state IDLE, FIFO empty, indices 0, flagChannelorData=0, InData=0.
- underrun and vec_count SHALL be unchanged.
REQ-030 Outputs flagChannelorData and InData SHALL be registered; s_ready SHALL be combinational.

Reset
REQ-031 While Reset=0 at a rising edge, the loader SHALL set:
- state IDLE, FIFO and assembly empty, indices 0.
- flagChannelorData=0, InData=0, underrun=0, vec_count=0.

Configuration
REQ-032 Macro SD_FRAME_LOADER_STATS_EN:
- Defined: vec_count SHALL increment by 1, saturating at 65535, on each non-underrun pop, and clear on Reset.
- Undefined: vec_count SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-033 Load R0..R9 = (k, -k) for k=0..9, then y0..y3 = (10+i, 20+i):
- Required: CH_WAIT, then flag=1 for exactly 3 cycles with lanes matching REQ-022 (beat2 lane pairs 2,3 zero).
- Then flag=0 with InData lanes 0..3 = 10..13 and lanes 4..7 = 20..23.
- vec_count=1 when SD_FRAME_LOADER_STATS_EN is defined.
REQ-034 Push 4 vectors before the channel completes:
- Required: s_ready=0 for data words while full.
- In RUN, pulse OutputReady once -> second vector on InData next cycle and a data word accepted again.
REQ-035 In RUN with the FIFO empty, pulse OutputReady -> underrun=1, InData=0 next cycle, vec_count unchanged.
REQ-036 In the same cycle, push y3 of a vector and pulse OutputReady with the FIFO holding 2 -> count stays 2, correct head order.
REQ-037 Assert flush in SEND1 -> IDLE next cycle, flag=0, s_ready=1 for s_type=0; Reset=0 mid-RUN -> all REQ-031 values.
